// File: rtl/branch_predictor_bimodal_if.sv
// Fetch-side lookup, retire-side training and perf-counter signals of the bimodal predictor.
// The master drives fetch and retire information; the slave (the predictor) returns predictions.
interface branch_predictor_bimodal_if #(
    parameter int ADDR_W = 64
);
    logic              frontend_stall;
    logic [ADDR_W-1:0] fetch_pc;
    logic [31:0]       fetch_instruction;
    logic [ADDR_W-1:0] pred_next_pc;
    logic              pred_taken;
    logic              pred_hit;

    logic              retire_valid;
    logic [ADDR_W-1:0] retire_pc;
    logic              retire_is_branch;
    logic              retire_taken;
    logic [ADDR_W-1:0] retire_target;
    logic              retire_mispredict;

    logic [31:0]       branch_count;
    logic [31:0]       mispredict_count;

    modport master (
        output frontend_stall, fetch_pc, fetch_instruction,
        output retire_valid, retire_pc, retire_is_branch, retire_taken,
        output retire_target, retire_mispredict,
        input  pred_next_pc, pred_taken, pred_hit,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  frontend_stall, fetch_pc, fetch_instruction,
        input  retire_valid, retire_pc, retire_is_branch, retire_taken,
        input  retire_target, retire_mispredict,
        output pred_next_pc, pred_taken, pred_hit,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_bimodal.sv
// Tagged BTB with saturating direction counters, static BTFN fallback and a registered retire update.
// Optional global-history indexing of the counters is enabled with BP_GSHARE_EN.
module branch_predictor_bimodal #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 64,
    parameter int TAG_W   = 16,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predictor_bimodal_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [6:0]       OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]       OPC_JAL    = 7'b1101111;
    localparam logic [CTR_W-1:0] CTR_MAX    = '1;
    localparam logic [CTR_W-1:0] CTR_MIN    = '0;
    localparam logic [CTR_W-1:0] CTR_WT     = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WN     = {1'b0, {(CTR_W-1){1'b1}}};

    // Per-entry state, assembled from the generate blocks below
    logic              valid_rd  [ENTRIES];
    logic [TAG_W-1:0]  tag_rd    [ENTRIES];
    logic [ADDR_W-1:0] target_rd [ENTRIES];
    logic [CTR_W-1:0]  ctr_rd    [ENTRIES];

    // Pending update record
    logic              upd_valid_reg;
    logic [ADDR_W-1:0] upd_pc_reg;
    logic              upd_taken_reg;
    logic [ADDR_W-1:0] upd_target_reg;

    logic [31:0]       branch_count_reg;
    logic [31:0]       mispredict_count_reg;

    logic [6:0]        opcode;
    logic              is_branch;
    logic              is_jal;
    logic              is_ctrl;
    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  fetch_ctr_idx;
    logic [TAG_W-1:0]  fetch_tag;
    logic [ADDR_W-1:0] b_imm;
    logic [ADDR_W-1:0] j_imm;
    logic [ADDR_W-1:0] seq_pc;
    logic              entry_hit;
    logic [CTR_W-1:0]  fetch_ctr;

    logic [IDX_W-1:0]  upd_idx;
    logic [IDX_W-1:0]  upd_ctr_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_match;
    logic [CTR_W-1:0]  ctr_cur;
    logic [CTR_W-1:0]  ctr_next;
    logic              target_we;
    logic              count_en;

    logic              unused_bits;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0]       ghr_reg;
    logic [GHR_W-1:0]       upd_ghr_reg;
    logic [IDX_W+GHR_W-1:0] fetch_ghr_ext;
    logic [IDX_W+GHR_W-1:0] upd_ghr_ext;

    // History longer than the index is truncated, shorter is zero-extended
    assign fetch_ghr_ext = {{IDX_W{1'b0}}, ghr_reg};
    assign upd_ghr_ext   = {{IDX_W{1'b0}}, upd_ghr_reg};
    assign fetch_ctr_idx = fetch_idx ^ fetch_ghr_ext[IDX_W-1:0];
    assign upd_ctr_idx   = upd_idx ^ upd_ghr_ext[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_reg     <= '0;
            upd_ghr_reg <= '0;
        end else if (bp.retire_valid && bp.retire_is_branch) begin
            upd_ghr_reg <= ghr_reg;
            ghr_reg     <= {ghr_reg[GHR_W-2:0], bp.retire_taken};
        end
    end
`else
    assign fetch_ctr_idx = fetch_idx;
    assign upd_ctr_idx   = upd_idx;
`endif

    // ---------------- Lookup ----------------
    assign opcode    = bp.fetch_instruction[6:0];
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_ctrl   = is_branch || is_jal;
    assign fetch_idx = bp.fetch_pc[IDX_W+1:2];
    assign fetch_tag = bp.fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign seq_pc    = bp.fetch_pc + ADDR_W'(4);

    assign b_imm = {{(ADDR_W-13){bp.fetch_instruction[31]}},
                    bp.fetch_instruction[31], bp.fetch_instruction[7],
                    bp.fetch_instruction[30:25], bp.fetch_instruction[11:8], 1'b0};
    assign j_imm = {{(ADDR_W-21){bp.fetch_instruction[31]}},
                    bp.fetch_instruction[31], bp.fetch_instruction[19:12],
                    bp.fetch_instruction[20], bp.fetch_instruction[30:21], 1'b0};

    assign entry_hit = valid_rd[fetch_idx] && (tag_rd[fetch_idx] == fetch_tag);
    assign fetch_ctr = ctr_rd[fetch_ctr_idx];

    always_comb begin
        bp.pred_next_pc = seq_pc;
        bp.pred_taken   = 1'b0;
        bp.pred_hit     = 1'b0;
        if (is_ctrl) begin
            if (entry_hit) begin
                bp.pred_hit   = 1'b1;
                bp.pred_taken = is_jal ? 1'b1 : fetch_ctr[CTR_W-1];
                if (bp.pred_taken) begin
                    bp.pred_next_pc = target_rd[fetch_idx];
                end
            end else if (is_jal) begin
                bp.pred_taken   = 1'b1;
                bp.pred_next_pc = bp.fetch_pc + j_imm;
            end else if (bp.fetch_instruction[31]) begin
                // Backward branch on a miss: assume a loop and predict taken
                bp.pred_taken   = 1'b1;
                bp.pred_next_pc = bp.fetch_pc + b_imm;
            end
        end
    end

    // ---------------- Update register ----------------
    assign count_en = bp.retire_valid && bp.retire_is_branch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_valid_reg  <= 1'b0;
            upd_pc_reg     <= '0;
            upd_taken_reg  <= 1'b0;
            upd_target_reg <= '0;
        end else begin
            upd_valid_reg <= count_en;
            if (count_en) begin
                upd_pc_reg     <= bp.retire_pc;
                upd_taken_reg  <= bp.retire_taken;
                upd_target_reg <= bp.retire_target;
            end
        end
    end

    // ---------------- Table write ----------------
    assign upd_idx   = upd_pc_reg[IDX_W+1:2];
    assign upd_tag   = upd_pc_reg[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_match = valid_rd[upd_idx] && (tag_rd[upd_idx] == upd_tag);
    assign ctr_cur   = ctr_rd[upd_ctr_idx];
    assign target_we = !upd_match || upd_taken_reg;

    always_comb begin
        ctr_next = ctr_cur;
        if (upd_match) begin
            if (upd_taken_reg) begin
                ctr_next = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_W'(1);
            end else begin
                ctr_next = (ctr_cur == CTR_MIN) ? ctr_cur : ctr_cur - CTR_W'(1);
            end
        end else begin
            ctr_next = upd_taken_reg ? CTR_WT : CTR_WN;
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic              valid_reg;
        logic [TAG_W-1:0]  tag_reg;
        logic [ADDR_W-1:0] target_reg;
        logic [CTR_W-1:0]  ctr_reg;
        logic              btb_sel;
        logic              ctr_sel;

        assign btb_sel = upd_valid_reg && (upd_idx == IDX_W'(gi));
        assign ctr_sel = upd_valid_reg && (upd_ctr_idx == IDX_W'(gi));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_reg  <= 1'b0;
                tag_reg    <= '0;
                target_reg <= '0;
                ctr_reg    <= '0;
            end else begin
                if (btb_sel) begin
                    valid_reg <= 1'b1;
                    tag_reg   <= upd_tag;
                    if (target_we) begin
                        target_reg <= upd_target_reg;
                    end
                end
                if (ctr_sel) begin
                    ctr_reg <= ctr_next;
                end
            end
        end

        assign valid_rd[gi]  = valid_reg;
        assign tag_rd[gi]    = tag_reg;
        assign target_rd[gi] = target_reg;
        assign ctr_rd[gi]    = ctr_reg;
    end

    // ---------------- Performance counters ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else if (count_en) begin
            if (branch_count_reg != 32'hFFFF_FFFF) begin
                branch_count_reg <= branch_count_reg + 32'd1;
            end
            if (bp.retire_mispredict && (mispredict_count_reg != 32'hFFFF_FFFF)) begin
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
            end
        end
    end

    assign bp.branch_count     = branch_count_reg;
    assign bp.mispredict_count = mispredict_count_reg;

    // Stall only freezes fetch_pc upstream; high PC bits beyond the tag are not stored
    assign unused_bits = ^{bp.frontend_stall, upd_pc_reg};

endmodule

// File: doc/branch_predictor_bimodal.md
Name: branch_predictor_bimodal

Overview:
Parametrised successor to the direct-mapped, 1-bit-toggle fetch predictor. It combines a tagged BTB with 2-bit (CTR_W) saturating direction counters, a static fallback for BTB misses, and a registered, non-speculative retire-side update path. It also provides branch and mispredict performance counters. The block sits beside the fetch PC register: it redirects fetch combinationally and is trained from the retire stage.

Parameters:
ENTRIES, 64, BTB/counter entries; power of two, minimum 4; IDX_W = log2(ENTRIES)
ADDR_W, 64, address width
TAG_W, 16, stored tag bits, taken from fetch_pc[IDX_W+2+TAG_W-1 : IDX_W+2]
CTR_W, 2, direction counter width; MSB=1 predicts taken
GHR_W, 8, global history length; used only when BP_GSHARE_EN is defined

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
frontend_stall  in  1  fetch held; no effect on table state
fetch_pc  in  ADDR_W  PC being fetched
fetch_instruction  in  32  instruction at fetch_pc
pred_next_pc  out  ADDR_W  predicted next PC
pred_taken  out  1  predicted taken; drives the fetch PC overwrite
pred_hit  out  1  BTB valid and tag match for a control instruction
retire_valid  in  1  retire slot valid
retire_pc  in  ADDR_W  PC of the retiring instruction
retire_is_branch  in  1  retiring instruction is a conditional branch or JAL
retire_taken  in  1  resolved direction
retire_target  in  ADDR_W  resolved taken target
retire_mispredict  in  1  retiring control instruction was mispredicted
branch_count  out  32  retired control instructions
mispredict_count  out  32  retired mispredicts

Behaviour:
- Reset (async on reset low): all valid bits=0, counters=0, pending update register cleared, GHR=0, perf counters=0. Combinational outputs follow from the cleared state: pred_hit=0, pred_taken=0, pred_next_pc=fetch_pc+4.
- Lookup (combinational, same cycle):
  - idx = fetch_pc[IDX_W+1:2].
  - Control instruction = opcode 7'b1100011 (B-type) or 7'b1101111 (JAL).
  - Non-control: pred_next_pc=fetch_pc+4, pred_taken=0, pred_hit=0.
  - Hit: pred_taken = counter MSB for B-type, 1 for JAL. pred_next_pc = taken ? stored target : fetch_pc+4.
  - Miss, B-type: static backward-taken/forward-not-taken. If imm[12]=1, pred_taken=1 and pred_next_pc=fetch_pc+sext(B-imm); otherwise fetch_pc+4.
  - Miss, JAL: pred_taken=1, pred_next_pc=fetch_pc+sext(J-imm).
  - The lookup never writes state.
- Update pipeline:
  - Cycle N: retire_valid && retire_is_branch latches {pc, taken, target} into the update register.
  - Edge N+1: the table is written.
  - A lookup of the same PC observes the new state from cycle N+2. There is no bypass.
- Table write:
  - Tag match (valid): counter saturating +1 if taken, -1 if not. Counter stays at 2^CTR_W-1 / 0 at the limits. Target written only when taken.
  - Tag miss or invalid: allocate (overwrite); valid=1, tag written, target=retire_target. Counter = taken ? 2^(CTR_W-1) (weakly taken) : 2^(CTR_W-1)-1 (weakly not-taken).
  - Back-to-back updates to the same index apply in retire order, each against the previous write.
- Perf counters:
  - branch_count +1 on retire_valid && retire_is_branch.
  - mispredict_count +1 when retire_mispredict is also high.
  - Both saturate at 32'hFFFF_FFFF.
- frontend_stall only holds fetch_pc externally. Updates proceed during a stall.
- Reset asserted mid-update discards the pending update. No partial write occurs.

Optional Feature:
BP_GSHARE_EN.
- Defined:
  - Counter index = fetch_pc[IDX_W+1:2] XOR zero-extended GHR; the BTB tag/target still use the PC index.
  - GHR (GHR_W bits) shifts in retire_taken on each latched update, non-speculatively.
  - The update uses the GHR value captured alongside the update record.
- Not defined: the GHR is absent and counters are PC-indexed.

Test Plan:
- After reset, fetch beq at 0x100 with imm -16 -> pred_next_pc=0xF0, pred_taken=1, pred_hit=0. Forward imm +32 -> 0x104, pred_taken=0.
- Retire taken branch pc=0x200, target=0x240 at cycle N -> fetch 0x200 at N+1 still misses. At N+2: pred_hit=1, pred_taken=1 (counter 2'b10), pred_next_pc=0x240.
- Four not-taken retires of 0x200 -> counter 2'b00, saturated. One taken retire -> 2'b01, pred_taken=0, pred_next_pc=0x204.
- Alias test: retire 0x200, then 0x200+ENTRIES*4 (same index, different tag) -> lookup of 0x200 gives pred_hit=0 and the static prediction.
- 5 branch retires with 2 mispredicts -> branch_count=5, mispredict_count=2. Drop reset low the cycle after a retire -> all counts 0 and the entry stays invalid.
- BP_GSHARE_EN: alternating T/N pattern on one branch trains two distinct counters -> after warm-up, the prediction matches each outcome.
